// File: rtl/audio_pkg.sv
// Shared constants and read-FSM state type for the smoothing audio FIFO.
// The smoothing weight is a fraction of COEF_ONE, applied with a COEF_SHIFT right shift.
package audio_pkg;

    localparam int COEF_ONE   = 16;
    localparam int COEF_SHIFT = 4;
    localparam int COEF_W     = 5;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        FILTER,
        PRESENT,
        ACKWAIT
    } rd_state_t;

    // Weights above unity saturate to unity.
    function automatic logic [COEF_W-1:0] clamp_coef(input logic [COEF_W-1:0] c);
        return (c > COEF_W'(COEF_ONE)) ? COEF_W'(COEF_ONE) : c;
    endfunction

endpackage

// File: rtl/audio_sdp_ram.sv
// Simple dual-port frame store: synchronous write, registered read, contents never cleared.
module audio_sdp_ram #(
    parameter int DATA_W = 36,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/audio_smooth_fifo.sv
// Multi-channel audio FIFO with 4-phase handshakes on both sides and a per-channel
// first-order smoothing filter (or raw bypass) applied as each frame is read out.
module audio_smooth_fifo
    import audio_pkg::*;
#(
    parameter int WIDTH      = 18,
    parameter int CHANNELS   = 2,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_ready,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic                      in_received,
    output logic                      out_valid,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    input  logic                      out_ack,
    input  logic [COEF_W-1:0]         coef,
    input  logic                      bypass,
    output logic [DEPTH_LOG2:0]       level,
    output logic                      full,
    output logic                      empty
);

    localparam int FRAME_W = CHANNELS * WIDTH;
    localparam int PTR_W   = DEPTH_LOG2 + 1;
    localparam int ACC_W   = WIDTH + 6;

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level_q, level_d;
    logic               full_q, empty_q, in_received_q;
    logic               wr_fire, rd_issue;
    rd_state_t          state_q, state_d;
    logic [FRAME_W-1:0] ram_rd_data, frame_q, y_all, y_prev_q, out_data_q;
    logic [COEF_W-1:0]  coef_a, coef_b;

    // in_received_q doubles as the "already served" flag until in_ready drops.
    assign wr_fire  = in_ready & ~in_received_q & ~full_q;
    assign rd_issue = (state_q == IDLE) & ~empty_q;

    assign wr_ptr_d = wr_ptr_q + PTR_W'(wr_fire);
    assign rd_ptr_d = rd_ptr_q + PTR_W'(rd_issue);
    assign level_d  = wr_ptr_d - rd_ptr_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            full_q        <= 1'b0;
            empty_q       <= 1'b1;
            in_received_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            full_q        <= (level_d == PTR_W'(1 << DEPTH_LOG2));
            empty_q       <= (level_d == '0);
            in_received_q <= in_ready & (in_received_q | wr_fire);
        end
    end

    audio_sdp_ram #(
        .DATA_W (FRAME_W),
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (wr_fire),
        .wr_addr_i (wr_ptr_q[DEPTH_LOG2-1:0]),
        .wr_data_i (in_data),
        .rd_en_i   (rd_issue),
        .rd_addr_i (rd_ptr_q[DEPTH_LOG2-1:0]),
        .rd_data_o (ram_rd_data)
    );

    always_ff @(posedge clk) begin
        if (state_q == FETCH) begin
            frame_q <= ram_rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (!empty_q) state_d = FETCH;
            FETCH:   state_d = FILTER;
            FILTER:  state_d = PRESENT;
            PRESENT: if (out_ack) state_d = ACKWAIT;
            ACKWAIT: if (!out_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Only consumed while in FILTER, so coef/bypass are effectively sampled there.
    assign coef_a = clamp_coef(coef);
    assign coef_b = COEF_W'(COEF_ONE) - coef_a;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic signed [WIDTH-1:0] x_s, yp_s;
            logic signed [ACC_W-1:0] acc;

            assign x_s  = $signed(frame_q[gi*WIDTH +: WIDTH]);
            assign yp_s = $signed(y_prev_q[gi*WIDTH +: WIDTH]);
            // a + b == unity, so the weighted sum cannot overflow ACC_W.
            assign acc  = ACC_W'(yp_s) * ACC_W'($signed({1'b0, coef_b}))
                        + ACC_W'(x_s)  * ACC_W'($signed({1'b0, coef_a}));
            assign y_all[gi*WIDTH +: WIDTH] = bypass ? frame_q[gi*WIDTH +: WIDTH]
                                                     : WIDTH'(acc >>> COEF_SHIFT);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            y_prev_q   <= '0;
            out_data_q <= '0;
        end else if (state_q == FILTER) begin
            y_prev_q   <= y_all;
            out_data_q <= y_all;
        end
    end

    assign in_received = in_received_q;
    assign out_valid   = (state_q == PRESENT);
    assign out_data    = out_data_q;
    assign level       = level_q;
    assign full        = full_q;
    assign empty       = empty_q;

endmodule
